// File: rtl/sar_adc_sequencer.sv
// Sequences a shared SAR ADC across the enabled mux channels of one frame,
// storing each result in its own slot and flagging frame completion on DATA_RDY.
module sar_adc_sequencer #(
  parameter int ADCBITDEPTH = 14,
  parameter int NUMCHANNELS = 16
) (
  input  logic                               CLK,
  input  logic                               NRST,
  input  logic                               start_conv,
  input  logic [NUMCHANNELS-1:0]             chan_en,
  input  logic [7:0]                         sample_cycles,
  input  logic                               comp_out,
  output logic [$clog2(NUMCHANNELS)-1:0]     mux_sel,
  output logic                               sample_en,
  output logic [ADCBITDEPTH-1:0]             dac_code,
  output logic [NUMCHANNELS*ADCBITDEPTH-1:0] adc_data,
  output logic                               DATA_RDY,
  output logic                               busy
);

  localparam int SW = $clog2(NUMCHANNELS);
  localparam int KW = $clog2(ADCBITDEPTH);
  localparam logic [ADCBITDEPTH-1:0] ADC_ONE = {{(ADCBITDEPTH-1){1'b0}}, 1'b1};
  localparam logic [ADCBITDEPTH-1:0] ADC_MSB = {1'b1, {(ADCBITDEPTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, SAMPLE, CONVERT, STORE, DONE} state_t;

  state_t                   state;
  logic                     sync1, sync2, sync3, start_pulse;
  logic [NUMCHANNELS-1:0]   en_q, en_left;
  logic [7:0]               s_q, cnt, s_eff, start_eff;
  logic [ADCBITDEPTH-1:0]   res, res_next;
  logic [KW-1:0]            k;
  logic [SW-1:0]            next_sel;

  function automatic logic [SW-1:0] lowest_set(input logic [NUMCHANNELS-1:0] m);
    lowest_set = '0;
    for (int i = NUMCHANNELS - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = SW'(i);
    end
  endfunction

  always_comb begin
    res_next    = res;
    res_next[k] = comp_out;
    en_left     = en_q;
    en_left[mux_sel] = 1'b0;
    next_sel    = lowest_set(en_left);
    s_eff       = (s_q == 8'd0) ? 8'd1 : s_q;
    start_eff   = (sample_cycles == 8'd0) ? 8'd1 : sample_cycles;
  end

  assign busy = (state == SAMPLE) || (state == CONVERT) || (state == STORE);

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state       <= IDLE;
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      sync3       <= 1'b0;
      start_pulse <= 1'b0;
      en_q        <= '0;
      s_q         <= '0;
      cnt         <= '0;
      res         <= '0;
      k           <= '0;
      mux_sel     <= '0;
      sample_en   <= 1'b0;
      dac_code    <= '0;
      adc_data    <= '0;
      DATA_RDY    <= 1'b0;
    end else begin
      sync1       <= start_conv;
      sync2       <= sync1;
      sync3       <= sync2;
      // Registered edge detect puts the SAMPLE entry three edges after capture.
      start_pulse <= sync2 & ~sync3;
      case (state)
        IDLE, DONE: begin
          if (start_pulse) begin
            en_q <= chan_en;
            s_q  <= sample_cycles;
            if (chan_en == '0) begin
              DATA_RDY <= 1'b1;
              state    <= DONE;
            end else begin
              DATA_RDY  <= 1'b0;
              mux_sel   <= lowest_set(chan_en);
              cnt       <= start_eff;
              sample_en <= 1'b1;
              state     <= SAMPLE;
            end
          end
        end
        SAMPLE: begin
          if (cnt <= 8'd1) begin
            sample_en <= 1'b0;
            res       <= '0;
            k         <= KW'(ADCBITDEPTH - 1);
            dac_code  <= ADC_MSB;
            state     <= CONVERT;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        CONVERT: begin
          res <= res_next;
          if (k == '0) begin
            dac_code <= '0;
            state    <= STORE;
          end else begin
            k        <= k - 1'b1;
            dac_code <= res_next | (ADC_ONE << (k - 1'b1));
          end
        end
        STORE: begin
          adc_data[int'(mux_sel)*ADCBITDEPTH +: ADCBITDEPTH] <= res;
          en_q <= en_left;
          if (en_left != '0) begin
            mux_sel   <= next_sel;
            cnt       <= s_eff;
            sample_en <= 1'b1;
            state     <= SAMPLE;
          end else begin
            DATA_RDY <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_sequencer.sv
// Directed bench for sar_adc_sequencer: a behavioural comparator resolves each
// channel against a per-channel input voltage table.
module tb_sar_adc_sequencer;

  logic         CLK = 1'b0;
  logic         NRST = 1'b0;
  logic         start_conv = 1'b0;
  logic [15:0]  chan_en = '0;
  logic [7:0]   sample_cycles = 8'd4;
  logic         comp_out;
  logic [3:0]   mux_sel;
  logic         sample_en;
  logic [13:0]  dac_code;
  logic [223:0] adc_data;
  logic         DATA_RDY;
  logic         busy;

  logic [13:0]  vin_tab [16];
  int           cyc;
  int           checks = 0;
  int           passed = 0;

  always #5 CLK = ~CLK;

  assign comp_out = (vin_tab[mux_sel] >= dac_code);

  sar_adc_sequencer dut (
    .CLK(CLK), .NRST(NRST), .start_conv(start_conv), .chan_en(chan_en),
    .sample_cycles(sample_cycles), .comp_out(comp_out), .mux_sel(mux_sel),
    .sample_en(sample_en), .dac_code(dac_code), .adc_data(adc_data),
    .DATA_RDY(DATA_RDY), .busy(busy)
  );

  function automatic logic [13:0] slot(input int j);
    slot = adc_data[j*14 +: 14];
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int t);
    while (cyc < t) tick();
  endtask

  // Raises start_conv; cyc = 0 marks the first edge that samples it high.
  task automatic start_frame();
    start_conv = 1'b1;
    tick();
    cyc = 0;
  endtask

  task automatic drop_start();
    start_conv = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    NRST = 1'b0;
    repeat (3) tick();
    checks++;
    if ({mux_sel, sample_en, dac_code, DATA_RDY, busy} !== '0 || adc_data !== '0)
      $display("FAIL reset_outputs: mux=%h se=%b dac=%h rdy=%b busy=%b data=%h want all 0",
               mux_sel, sample_en, dac_code, DATA_RDY, busy, adc_data);
    else passed++;
    NRST = 1'b1;
    tick();
  endtask

  task automatic test_single();
    chan_en = 16'h0001; sample_cycles = 8'd4; vin_tab[0] = 14'h1555;
    start_frame();
    go_to(2);
    checks++;
    if (sample_en !== 1'b0 || busy !== 1'b0) $display("FAIL single_early: se=%b busy=%b want 0 0", sample_en, busy);
    else passed++;
    go_to(3);
    checks++;
    if (sample_en !== 1'b1 || busy !== 1'b1 || mux_sel !== 4'd0)
      $display("FAIL single_sample_entry: se=%b busy=%b mux=%h want 1 1 0", sample_en, busy, mux_sel);
    else passed++;
    go_to(7);
    checks++;
    if (dac_code !== 14'h2000 || sample_en !== 1'b0) $display("FAIL single_dac0: dac=%h se=%b want 2000 0", dac_code, sample_en);
    else passed++;
    go_to(8);
    checks++;
    if (dac_code !== 14'h1000) $display("FAIL single_dac1: dac=%h want 1000", dac_code);
    else passed++;
    go_to(9);
    checks++;
    if (dac_code !== 14'h1800) $display("FAIL single_dac2: dac=%h want 1800", dac_code);
    else passed++;
    go_to(21);
    checks++;
    if (DATA_RDY !== 1'b0 || busy !== 1'b1) $display("FAIL single_rdy_early: rdy=%b busy=%b want 0 1", DATA_RDY, busy);
    else passed++;
    go_to(22);
    checks++;
    if (DATA_RDY !== 1'b1 || busy !== 1'b0 || slot(0) !== 14'h1555)
      $display("FAIL single_done: rdy=%b busy=%b slot0=%h want 1 0 1555", DATA_RDY, busy, slot(0));
    else passed++;
    drop_start();
  endtask

  task automatic test_full_scale();
    chan_en = 16'h8001; sample_cycles = 8'd4;
    vin_tab[0] = 14'h3FFF; vin_tab[15] = 14'h0000;
    start_frame();
    go_to(3);
    checks++;
    if (mux_sel !== 4'd0 || DATA_RDY !== 1'b0) $display("FAIL fs_first_ch: mux=%h rdy=%b want 0 0", mux_sel, DATA_RDY);
    else passed++;
    go_to(22);
    checks++;
    if (mux_sel !== 4'd15 || sample_en !== 1'b1) $display("FAIL fs_second_ch: mux=%h se=%b want f 1", mux_sel, sample_en);
    else passed++;
    go_to(40);
    checks++;
    if (DATA_RDY !== 1'b0) $display("FAIL fs_rdy_early: rdy=%b want 0", DATA_RDY);
    else passed++;
    go_to(41);
    checks++;
    if (DATA_RDY !== 1'b1 || slot(0) !== 14'h3FFF || slot(15) !== 14'h0000)
      $display("FAIL fs_done: rdy=%b slot0=%h slot15=%h want 1 3fff 0000", DATA_RDY, slot(0), slot(15));
    else passed++;
    drop_start();
  endtask

  task automatic test_retention();
    for (int i = 0; i < 16; i++) vin_tab[i] = 14'h0AAA;
    chan_en = 16'hFFFF; sample_cycles = 8'd4;
    start_frame();
    go_to(307);
    checks++;
    if (DATA_RDY !== 1'b1) $display("FAIL ret_preload_done: rdy=%b want 1", DATA_RDY);
    else passed++;
    drop_start();
    vin_tab[2] = 14'h0123; vin_tab[5] = 14'h3210;
    chan_en = 16'h0024;
    start_frame();
    go_to(41);
    checks++;
    if (DATA_RDY !== 1'b1) $display("FAIL ret_done: rdy=%b want 1", DATA_RDY);
    else passed++;
    for (int j = 0; j < 16; j++) begin
      logic [13:0] want;
      want = (j == 2) ? 14'h0123 : (j == 5) ? 14'h3210 : 14'h0AAA;
      checks++;
      if (slot(j) !== want) $display("FAIL ret_slot%0d: got %h want %h", j, slot(j), want);
      else passed++;
    end
    drop_start();
  endtask

  task automatic test_empty_and_s0();
    int busy_seen;
    int se_cnt;
    NRST = 1'b0;
    tick();
    NRST = 1'b1;
    tick();
    chan_en = 16'h0000;
    busy_seen = 0;
    start_frame();
    if (busy) busy_seen++;
    while (cyc < 2) begin tick(); if (busy) busy_seen++; end
    checks++;
    if (DATA_RDY !== 1'b0) $display("FAIL empty_rdy_early: rdy=%b want 0", DATA_RDY);
    else passed++;
    go_to(3);
    checks++;
    if (DATA_RDY !== 1'b1) $display("FAIL empty_rdy: rdy=%b want 1", DATA_RDY);
    else passed++;
    while (cyc < 15) begin tick(); if (busy) busy_seen++; end
    checks++;
    if (busy_seen !== 0) $display("FAIL empty_busy: busy cycles %0d want 0", busy_seen);
    else passed++;
    drop_start();
    chan_en = 16'h0001; sample_cycles = 8'd0; vin_tab[0] = 14'h2B3C;
    se_cnt = 0;
    start_frame();
    while (cyc < 18) begin tick(); if (sample_en) se_cnt++; end
    checks++;
    if (se_cnt !== 1 || DATA_RDY !== 1'b0) $display("FAIL s0_sample_len: cycles %0d rdy=%b want 1 0", se_cnt, DATA_RDY);
    else passed++;
    go_to(19);
    checks++;
    if (DATA_RDY !== 1'b1 || slot(0) !== 14'h2B3C) $display("FAIL s0_done: rdy=%b slot0=%h want 1 2b3c", DATA_RDY, slot(0));
    else passed++;
    drop_start();
  endtask

  task automatic test_retrigger();
    int busy_seen;
    chan_en = 16'h0003; sample_cycles = 8'd2;
    vin_tab[0] = 14'h0F0F; vin_tab[1] = 14'h2468;
    start_frame();
    go_to(8);
    start_conv = 1'b0;
    go_to(11);
    start_conv = 1'b1;
    go_to(36);
    checks++;
    if (DATA_RDY !== 1'b0 || busy !== 1'b1) $display("FAIL retrig_rdy_early: rdy=%b busy=%b want 0 1", DATA_RDY, busy);
    else passed++;
    go_to(37);
    checks++;
    if (DATA_RDY !== 1'b1 || slot(0) !== 14'h0F0F || slot(1) !== 14'h2468)
      $display("FAIL retrig_done: rdy=%b s0=%h s1=%h want 1 0f0f 2468", DATA_RDY, slot(0), slot(1));
    else passed++;
    busy_seen = 0;
    while (cyc < 70) begin tick(); if (busy) busy_seen++; end
    checks++;
    if (busy_seen !== 0 || DATA_RDY !== 1'b1) $display("FAIL retrig_no_second: busy cycles %0d rdy=%b want 0 1", busy_seen, DATA_RDY);
    else passed++;
    drop_start();
    chan_en = 16'h0001; vin_tab[0] = 14'h0001;
    start_frame();
    go_to(3);
    checks++;
    if (DATA_RDY !== 1'b0 || busy !== 1'b1) $display("FAIL retrig_new_start: rdy=%b busy=%b want 0 1", DATA_RDY, busy);
    else passed++;
    go_to(20);
    checks++;
    if (DATA_RDY !== 1'b1 || slot(0) !== 14'h0001) $display("FAIL retrig_new_done: rdy=%b s0=%h want 1 0001", DATA_RDY, slot(0));
    else passed++;
    drop_start();
  endtask

  task automatic test_reset_mid();
    int act;
    for (int i = 0; i < 16; i++) vin_tab[i] = 14'h1000 + 14'(i);
    chan_en = 16'hFFFF; sample_cycles = 8'd4;
    start_frame();
    go_to(70);
    checks++;
    if (mux_sel !== 4'd3 || busy !== 1'b1 || sample_en !== 1'b0)
      $display("FAIL rstmid_pre: mux=%h busy=%b se=%b want 3 1 0", mux_sel, busy, sample_en);
    else passed++;
    NRST = 1'b0;
    start_conv = 1'b0;
    tick();
    checks++;
    if ({mux_sel, sample_en, dac_code, DATA_RDY, busy} !== '0 || adc_data !== '0)
      $display("FAIL rstmid_outputs: mux=%h se=%b dac=%h rdy=%b busy=%b data=%h want all 0",
               mux_sel, sample_en, dac_code, DATA_RDY, busy, adc_data);
    else passed++;
    tick();
    NRST = 1'b1;
    act = 0;
    repeat (20) begin tick(); if (busy || sample_en || DATA_RDY) act++; end
    checks++;
    if (act !== 0) $display("FAIL rstmid_idle: active cycles %0d want 0", act);
    else passed++;
    chan_en = 16'h0001;
    start_frame();
    go_to(3);
    checks++;
    if (busy !== 1'b1 || sample_en !== 1'b1) $display("FAIL rstmid_restart: busy=%b se=%b want 1 1", busy, sample_en);
    else passed++;
    go_to(22);
    checks++;
    if (DATA_RDY !== 1'b1 || slot(0) !== 14'h1000) $display("FAIL rstmid_done: rdy=%b s0=%h want 1 1000", DATA_RDY, slot(0));
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) vin_tab[i] = '0;
    cyc = 0;
    test_reset();
    test_single();
    test_full_scale();
    test_retention();
    test_empty_and_s0();
    test_retrigger();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
